// File: rtl/alu_op_issue_queue.sv
// Command FIFO feeding the ALU input handshake with a held issue register.
// Optional ALU_OPQ_STATS_EN adds issued_cnt / drop_cnt statistics outputs.
module alu_op_issue_queue #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  input  logic                       flush,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [OP_W-1:0]            alu_op,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
`ifdef ALU_OPQ_STATS_EN
  output logic [15:0]                issued_cnt,
  output logic [15:0]                drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OP_W + 2 * DATA_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [0:0]    state;
  logic          push;
  logic          pop;
  logic          xfer;

  assign alu_valid = (state == DRIVE);
  assign in_ready  = !reset && !flush && (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign xfer      = alu_valid && alu_ready && !flush;
  // Refill the issue register when it is empty or draining this cycle
  assign pop       = !flush && (count != '0) && (!alu_valid || alu_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {in_op, in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      state  <= IDLE;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        {alu_op, alu_a, alu_b} <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        state <= DRIVE;
      end else if (xfer) begin
        state <= IDLE;
      end
    end
  end

`ifdef ALU_OPQ_STATS_EN
  logic [16:0] dsum;

  assign dsum = {1'b0, drop_cnt} + 17'(count) + 17'(alu_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (xfer) begin
        issued_cnt <= issued_cnt + 16'd1;
      end
      if (flush) begin
        drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_issue_queue.sv
// Randomized scoreboard bench for alu_op_issue_queue.
// Checks stats outputs too when ALU_OPQ_STATS_EN is defined.
module tb_alu_op_issue_queue;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       flush;
  logic       alu_valid;
  logic       alu_ready;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] count;
`ifdef ALU_OPQ_STATS_EN
  logic [15:0] issued_cnt;
  logic [15:0] drop_cnt;
`endif

  alu_op_issue_queue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
`ifdef ALU_OPQ_STATS_EN
    .issued_cnt(issued_cnt), .drop_cnt(drop_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  cmd_t sb[$];
  cmd_t mq[$];
  cmd_t slot;
  bit   slot_v;
  int   m_iss;
  int   m_drop;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && alu_valid && alu_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected actual=1 required=0 t=%0t", $time);
        end else begin
          cmd_t e;
          e = sb.pop_front();
          chk("xfer_op", alu_op, e.op);
          chk("xfer_a", alu_a, e.a);
          chk("xfer_b", alu_b, e.b);
        end
      end
    end
  end

  task automatic model_clear();
    mq.delete();
    sb.delete();
    slot_v = 0;
    m_iss  = 0;
    m_drop = 0;
  endtask

  task automatic do_reset(int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
`ifdef ALU_OPQ_STATS_EN
    chk("rst_issued", issued_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic step(bit iv, cmd_t c, bit ar, bit fl);
    bit exp_rdy;
    bit acc;
    bit xf;
    in_valid  = iv;
    in_op     = c.op;
    in_a      = c.a;
    in_b      = c.b;
    alu_ready = ar;
    flush     = fl;
    exp_rdy   = (mq.size() < 4) && !fl;
    acc       = iv && exp_rdy;
    @(negedge clk);
    chk("count", count, mq.size());
    chk("in_ready", in_ready, exp_rdy);
    chk("alu_valid", alu_valid, slot_v);
    if (slot_v) begin
      chk("hold_op", alu_op, slot.op);
      chk("hold_a", alu_a, slot.a);
      chk("hold_b", alu_b, slot.b);
    end
`ifdef ALU_OPQ_STATS_EN
    chk("issued_cnt", issued_cnt, m_iss);
    chk("drop_cnt", drop_cnt, m_drop);
`endif
    if (acc) sb.push_back(c);
    if (fl) sb.delete();
    @(posedge clk);
    if (fl) begin
      m_drop = m_drop + mq.size() + int'(slot_v);
      if (m_drop > 65535) m_drop = 65535;
      mq.delete();
      slot_v = 0;
    end else begin
      xf = slot_v && ar;
      if (xf) m_iss = (m_iss + 1) % 65536;
      if ((!slot_v || xf) && mq.size() > 0) begin
        slot   = mq.pop_front();
        slot_v = 1;
      end else if (xf) begin
        slot_v = 0;
      end
      if (acc) mq.push_back(c);
    end
    #1;
  endtask

  function automatic cmd_t rnd();
    cmd_t c;
    c.op = 3'($urandom);
    c.a  = 8'($urandom);
    c.b  = 8'($urandom);
    return c;
  endfunction

  function automatic cmd_t mk(int op, int a, int b);
    cmd_t c;
    c.op = 3'(op);
    c.a  = 8'(a);
    c.b  = 8'(b);
    return c;
  endfunction

  initial begin
    cmd_t z;
    z = mk(0, 0, 0);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    flush     = 1'b0;
    alu_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset(2);

    step(1, mk(1, 8'h05, 8'h03), 1, 0);
    repeat (4) step(0, z, 1, 0);

    for (int i = 0; i < 5; i++) step(1, rnd(), 0, 0);
    step(0, z, 0, 0);
    repeat (7) step(0, z, 1, 0);

    step(1, mk(2, 8'hFF, 8'h01), 0, 0);
    for (int i = 0; i < 4; i++) step(0, mk(0, i * 37, ~i), 0, 0);
    step(0, z, 1, 0);
    step(0, z, 1, 0);

    for (int i = 0; i < 4; i++) step(1, rnd(), 0, 0);
    step(0, z, 0, 0);
    step(1, rnd(), 1, 1);
    repeat (3) step(0, z, 1, 0);

    for (int i = 0; i < 5; i++) step(1, rnd(), 0, 0);
    step(1, rnd(), 1, 0);
    step(1, rnd(), 0, 0);
    step(0, z, 0, 0);
    repeat (7) step(0, z, 1, 0);

    for (int i = 0; i < 3; i++) step(1, rnd(), 0, 0);
    do_reset(1);

    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 3) != 0), rnd(),
           bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 29) == 0));
    end
    repeat (8) step(0, z, 1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
